// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - region encoding, map offsets and address decode for mem_map_ctrl
package mem_map_pkg;

   typedef enum logic [2:0] {
      REG_RAM,
      REG_SW,
      REG_GPIO,
      REG_GSET,
      REG_GCLR,
      REG_STAT,
      REG_ROM,
      REG_NONE
   } region_e;

   localparam int unsigned SW_OFS   = 0;
   localparam int unsigned GPIO_OFS = 1;
   localparam int unsigned GSET_OFS = 2;
   localparam int unsigned GCLR_OFS = 3;
   localparam int unsigned STAT_OFS = 4;
   localparam int unsigned ROM_OFS  = 5;

   // Widened to 64 bits so the ROM end bound can never wrap for any legal AW.
   function automatic region_e decode(input logic [63:0] addr,
                                      input logic [63:0] ram_words,
                                      input logic [63:0] rom_words);
      logic [63:0] rom_base;
      region_e     r;
      rom_base = ram_words + 64'(ROM_OFS);
      if (addr < ram_words)                                      r = REG_RAM;
      else if (addr == ram_words + 64'(SW_OFS))                  r = REG_SW;
      else if (addr == ram_words + 64'(GPIO_OFS))                r = REG_GPIO;
      else if (addr == ram_words + 64'(GSET_OFS))                r = REG_GSET;
      else if (addr == ram_words + 64'(GCLR_OFS))                r = REG_GCLR;
      else if (addr == ram_words + 64'(STAT_OFS))                r = REG_STAT;
      else if (addr >= rom_base && addr < rom_base + rom_words)  r = REG_ROM;
      else                                                       r = REG_NONE;
      return r;
   endfunction

endpackage

// File: rtl/mem_map_ctrl_if.sv
// rtl/mem_map_ctrl_if.sv - CPU data port bundle for mem_map_ctrl
interface mem_map_ctrl_if #(
   parameter int AW = 32,
   parameter int DW = 32
) ();
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic          rvalid;

   modport master (output req, we, addr, wdata, input  rdata, rvalid);
   modport slave  (input  req, we, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/input_sync.sv
// rtl/input_sync.sv - per-bit two-flop synchroniser with async active-low reset
module input_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] meta_q, meta_d;
   logic [W-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;
endmodule

// File: rtl/mem_map_ctrl.sv
// rtl/mem_map_ctrl.sv - CPU data-port decoder for RAM, ROM, switches, GPIO and status
module mem_map_ctrl
   import mem_map_pkg::*;
#(
   parameter int unsigned RAM_WORDS = 57600,
   parameter int unsigned ROM_WORDS = 100,
   parameter int          N_SW      = 1,
   parameter int          N_GPIO    = 1,
   parameter int          AW        = 32,
   parameter int          DW        = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_map_ctrl_if.slave     bus,
   output logic [AW-1:0]     ram_addr,
   output logic              ram_we,
   output logic [DW-1:0]     ram_wdata,
   input  logic [DW-1:0]     ram_rdata,
   output logic [AW-1:0]     rom_addr,
   input  logic [DW-1:0]     rom_rdata,
   input  logic [N_SW-1:0]   sw_in,
   output logic [N_GPIO-1:0] gpio,
   output logic              gpio_stb,
   output logic              err
);
   localparam logic [64:0]   ROM_END  = 65'(RAM_WORDS) + 65'(ROM_OFS) + 65'(ROM_WORDS);
   localparam logic [AW-1:0] ROM_BASE = AW'(65'(RAM_WORDS) + 65'(ROM_OFS));

   if ((ROM_END >> AW) != 65'd0) begin : g_bad_map
      $error("mem_map_ctrl: ROM_BASE+ROM_WORDS must be below 2**AW");
   end
   if (N_SW < 1 || N_SW > 32 || N_GPIO < 1 || N_GPIO > 32 || N_GPIO > DW || N_SW > DW) begin : g_bad_width
      $error("mem_map_ctrl: N_SW/N_GPIO out of range");
   end

   region_e           region;
   region_e           rsel_q, rsel_d;
   logic              wr, rd, illegal;
   logic              rvalid_q, rvalid_d;
   logic              gpio_stb_q, gpio_stb_d;
   logic              err_q, err_d;
   logic [AW-1:0]     err_addr_q, err_addr_d;
   logic [DW-1:0]     hold_q, hold_d;
   logic [N_GPIO-1:0] gpio_q, gpio_d, wmask;
   logic [N_SW-1:0]   sw_sync;

   input_sync #(.W(N_SW)) u_sw_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sw_in),
      .q     (sw_sync)
   );

   always_comb begin
      region    = decode(64'(bus.addr), 64'(RAM_WORDS), 64'(ROM_WORDS));
      wr        = bus.req & bus.we;
      rd        = bus.req & ~bus.we;
      illegal   = bus.req & ((region == REG_NONE) |
                             (bus.we & ((region == REG_ROM) | (region == REG_SW))));
      ram_we    = wr & (region == REG_RAM);
      ram_addr  = (region == REG_RAM) ? bus.addr : '0;
      rom_addr  = (region == REG_ROM) ? bus.addr - ROM_BASE : '0;
      ram_wdata = bus.wdata;
      wmask     = bus.wdata[N_GPIO-1:0];
   end

   // Register-file sources are captured at the request edge; RAM/ROM data arrive next cycle.
   always_comb begin
      rvalid_d   = rd;
      rsel_d     = region;
      hold_d     = '0;
      gpio_d     = gpio_q;
      gpio_stb_d = 1'b0;
      err_d      = err_q;
      err_addr_d = err_addr_q;
      if (rd) begin
         case (region)
            REG_SW:   hold_d = DW'(sw_sync);
            REG_GPIO: hold_d = DW'(gpio_q);
            REG_STAT: hold_d = DW'({err_addr_q, err_q});
            default:  hold_d = '0;
         endcase
      end
      if (wr) begin
         case (region)
            REG_GPIO: gpio_d = wmask;
            REG_GSET: gpio_d = gpio_q | wmask;
            REG_GCLR: gpio_d = gpio_q & ~wmask;
            REG_STAT: err_d  = 1'b0;
            default:  gpio_d = gpio_q;
         endcase
         gpio_stb_d = (region == REG_GPIO) | (region == REG_GSET) | (region == REG_GCLR);
      end
      if (illegal && !err_q) begin
         err_d      = 1'b1;
         err_addr_d = bus.addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_q   <= 1'b0;
         rsel_q     <= REG_NONE;
         hold_q     <= '0;
         gpio_q     <= '0;
         gpio_stb_q <= 1'b0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         rvalid_q   <= rvalid_d;
         rsel_q     <= rsel_d;
         hold_q     <= hold_d;
         gpio_q     <= gpio_d;
         gpio_stb_q <= gpio_stb_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   always_comb begin
      bus.rdata = '0;
      if (rvalid_q) begin
         case (rsel_q)
            REG_RAM: bus.rdata = ram_rdata;
            REG_ROM: bus.rdata = rom_rdata;
            default: bus.rdata = hold_q;
         endcase
      end
   end

   assign bus.rvalid = rvalid_q;
   assign gpio       = gpio_q;
   assign gpio_stb   = gpio_stb_q;
   assign err        = err_q;
endmodule

// File: tb/tb_mem_map_ctrl.sv
// tb/tb_mem_map_ctrl.sv - scoreboard bench for mem_map_ctrl at default parameters
module tb_mem_map_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] ram_addr, ram_wdata, rom_addr;
   logic [31:0] ram_rdata = '0;
   logic [31:0] rom_rdata = '0;
   logic        ram_we, gpio_stb, err;
   logic [0:0]  sw_in = 1'b0;
   logic [0:0]  gpio;
   logic [31:0] exp_q[$];
   logic [31:0] ram_mem [int unsigned];
   logic [31:0] exp;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   mem_map_ctrl_if #(.AW(32), .DW(32)) bus ();

   mem_map_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .rom_addr  (rom_addr),
      .rom_rdata (rom_rdata),
      .sw_in     (sw_in),
      .gpio      (gpio),
      .gpio_stb  (gpio_stb),
      .err       (err)
   );

   always @(posedge clk) begin
      ram_rdata <= ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : 32'h0;
      if (ram_we) ram_mem[ram_addr] = ram_wdata;
      rom_rdata <= 32'hC0DE_0000 ^ rom_addr;
   end

   task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      bus.req = r; bus.we = w; bus.addr = a; bus.wdata = d;
   endtask

   function automatic logic [31:0] pop_exp();
      if (exp_q.size() == 0) return 32'hxxxx_xxxx;
      return exp_q.pop_front();
   endfunction

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({bus.rvalid, bus.rdata} !== 33'h0) begin
         failures++; $display("FAIL reset_read rvalid=%b rdata=%h expected 0/0", bus.rvalid, bus.rdata);
      end
      checks++;
      if ({gpio, gpio_stb, err} !== 3'b000) begin
         failures++; $display("FAIL reset_regs gpio=%b stb=%b err=%b expected 0", gpio, gpio_stb, err);
      end
   endtask

   task automatic test_ram();
      @(negedge clk); drive(1, 1, 32'd57599, 32'hDEAD); #1;
      checks++;
      if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 32'd57599, 32'hDEAD}) begin
         failures++; $display("FAIL ram_write we=%b addr=%0d wdata=%h expected 1/57599/dead", ram_we, ram_addr, ram_wdata);
      end
      @(negedge clk); drive(1, 0, 32'd57599, 0); exp_q.push_back(32'hDEAD);
      @(negedge clk); drive(0, 0, 0, 0);
      exp = pop_exp(); checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== exp) begin
         failures++; $display("FAIL ram_read rvalid=%b rdata=%h expected 1/%h", bus.rvalid, bus.rdata, exp);
      end
      @(negedge clk);
      checks++;
      if ({bus.rvalid, bus.rdata} !== 33'h0) begin
         failures++; $display("FAIL idle_rdata rvalid=%b rdata=%h expected 0/0", bus.rvalid, bus.rdata);
      end
   endtask

   task automatic test_rom();
      @(negedge clk); drive(1, 0, 32'd57605, 0); exp_q.push_back(32'hC0DE_0000); #1;
      checks++;
      if (rom_addr !== 32'd0) begin failures++; $display("FAIL rom_first addr=%0d expected 0", rom_addr); end
      @(negedge clk); drive(1, 0, 32'd57704, 0); exp_q.push_back(32'hC0DE_0000 ^ 32'd99);
      exp = pop_exp(); checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== exp) begin
         failures++; $display("FAIL rom_read0 rvalid=%b rdata=%h expected 1/%h", bus.rvalid, bus.rdata, exp);
      end
      #1; checks++;
      if (rom_addr !== 32'd99) begin failures++; $display("FAIL rom_last addr=%0d expected 99", rom_addr); end
      @(negedge clk); drive(1, 0, 32'd57705, 0); exp_q.push_back(32'h0);
      exp = pop_exp(); checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== exp) begin
         failures++; $display("FAIL rom_read99 rvalid=%b rdata=%h expected 1/%h", bus.rvalid, bus.rdata, exp);
      end
      #1; checks++;
      if (rom_addr !== 32'd0) begin failures++; $display("FAIL rom_past addr=%0d expected 0", rom_addr); end
      @(negedge clk); drive(1, 1, 32'd57604, 32'h1234);
      exp = pop_exp(); checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== exp || err !== 1'b1) begin
         failures++; $display("FAIL rom_none rvalid=%b rdata=%h err=%b expected 1/%h/1", bus.rvalid, bus.rdata, err, exp);
      end
      @(negedge clk); drive(0, 0, 0, 0);
      checks++;
      if (err !== 1'b0) begin failures++; $display("FAIL stat_clear err=%b expected 0", err); end
   endtask

   task automatic test_gpio();
      @(negedge clk); drive(1, 1, 32'd57601, 1);
      @(negedge clk); drive(1, 1, 32'd57603, 1);
      checks++;
      if ({gpio, gpio_stb} !== 2'b11) begin failures++; $display("FAIL gpio_write gpio=%b stb=%b expected 1/1", gpio, gpio_stb); end
      @(negedge clk); drive(1, 1, 32'd57602, 1);
      checks++;
      if ({gpio, gpio_stb} !== 2'b01) begin failures++; $display("FAIL gpio_clr gpio=%b stb=%b expected 0/1", gpio, gpio_stb); end
      @(negedge clk); drive(1, 0, 32'd57601, 0); exp_q.push_back(32'h1);
      checks++;
      if ({gpio, gpio_stb} !== 2'b11) begin failures++; $display("FAIL gpio_set gpio=%b stb=%b expected 1/1", gpio, gpio_stb); end
      @(negedge clk); drive(1, 1, 32'd57602, 1);
      exp = pop_exp(); checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== exp || gpio_stb !== 1'b0) begin
         failures++; $display("FAIL gpio_readback rvalid=%b rdata=%h stb=%b expected 1/%h/0", bus.rvalid, bus.rdata, gpio_stb, exp);
      end
      @(negedge clk); drive(0, 0, 0, 0);
      checks++;
      if ({gpio, gpio_stb} !== 2'b11) begin failures++; $display("FAIL gpio_same gpio=%b stb=%b expected 1/1", gpio, gpio_stb); end
      @(negedge clk);
      checks++;
      if (gpio_stb !== 1'b0) begin failures++; $display("FAIL gpio_stb_len stb=%b expected 0", gpio_stb); end
   endtask

   task automatic test_back_to_back_sw();
      @(negedge clk); sw_in = 1'b1;
      @(negedge clk); drive(1, 0, 32'd57600, 0); exp_q.push_back(32'h0);
      @(negedge clk); drive(1, 0, 32'd57600, 0); exp_q.push_back(32'h1);
      exp = pop_exp(); checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== exp) begin
         failures++; $display("FAIL sw_early rvalid=%b rdata=%h expected 1/%h", bus.rvalid, bus.rdata, exp);
      end
      @(negedge clk); drive(0, 0, 0, 0);
      exp = pop_exp(); checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== exp) begin
         failures++; $display("FAIL sw_late rvalid=%b rdata=%h expected 1/%h", bus.rvalid, bus.rdata, exp);
      end
   endtask

   task automatic test_err();
      @(negedge clk); drive(1, 1, 32'd57610, 32'h5); #1;
      checks++;
      if (ram_we !== 1'b0) begin failures++; $display("FAIL rom_write_ramwe we=%b expected 0", ram_we); end
      @(negedge clk); drive(1, 0, 32'd60000, 0); exp_q.push_back(32'h0);
      checks++;
      if (err !== 1'b1) begin failures++; $display("FAIL err_set err=%b expected 1", err); end
      @(negedge clk); drive(1, 0, 32'd57604, 0); exp_q.push_back((32'd57610 << 1) | 32'd1);
      exp = pop_exp(); checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== exp) begin
         failures++; $display("FAIL none_read rvalid=%b rdata=%h expected 1/%h", bus.rvalid, bus.rdata, exp);
      end
      @(negedge clk); drive(1, 1, 32'd57604, 32'hFFFF_FFFF);
      exp = pop_exp(); checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== exp) begin
         failures++; $display("FAIL stat_read rvalid=%b rdata=%h expected 1/%h", bus.rvalid, bus.rdata, exp);
      end
      @(negedge clk); drive(1, 0, 32'd57604, 0); exp_q.push_back(32'd57610 << 1);
      checks++;
      if (err !== 1'b0) begin failures++; $display("FAIL stat_write err=%b expected 0", err); end
      @(negedge clk); drive(0, 0, 0, 0);
      exp = pop_exp(); checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== exp) begin
         failures++; $display("FAIL stat_held rvalid=%b rdata=%h expected 1/%h", bus.rvalid, bus.rdata, exp);
      end
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk); drive(1, 1, 32'd57600, 0);
      @(negedge clk); drive(1, 0, 32'd57599, 0);
      checks++;
      if ({gpio, err} !== 2'b11) begin failures++; $display("FAIL pre_reset gpio=%b err=%b expected 1/1", gpio, err); end
      @(posedge clk); #1; rst_n = 1'b0; drive(0, 0, 0, 0); #1;
      checks++;
      if ({bus.rvalid, bus.rdata, gpio, gpio_stb, err} !== 36'h0) begin
         failures++; $display("FAIL async_reset rvalid=%b rdata=%h gpio=%b stb=%b err=%b expected all 0",
                              bus.rvalid, bus.rdata, gpio, gpio_stb, err);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL post_reset_rvalid cycle=%0d rvalid=%b expected 0", i, bus.rvalid); end
      end
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left size=%0d expected 0", exp_q.size()); end
   endtask

   initial begin
      drive(0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_ram();
      test_rom();
      test_gpio();
      test_back_to_back_sw();
      test_err();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end
endmodule
